i2s_rx_sequencer: RTL and testbench

Controller for the I2S receive front end; sits between the raw I2S pins and the receiver datapath, ahead of the S/PDIF encoder.
- Synchronises SCK/WS into the system clock and checks WS framing (bits per channel).
- Holds the receiver enable (`rx_en`) off until the stream is locked.
- Captures each completed stereo frame from the receiver outputs and hands it downstream over a valid/ready interface, with overflow and error status.

---
 rtl/i2s_rx_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_i2s_rx_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx_sequencer.sv
// I2S receive sequencer: SCK/WS sync, WS framing lock, stereo frame capture.
// Define I2S_RX_FRAME_CNT_EN to add the 16-bit frame_count output.
module i2s_rx_sequencer #(
  parameter int BITS_PER_CH = 32,
  parameter int LOCK_FRAMES = 4,
  parameter int TIMEOUT     = 255,
  parameter int CAPTURE_DLY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        sck,
  input  logic        ws,
  input  logic [31:0] rx_data_left,
  input  logic [31:0] rx_data_right,
  output logic        rx_en,
  output logic        locked,
  output logic        smp_valid,
  input  logic        smp_ready,
  output logic [31:0] smp_left,
  output logic [31:0] smp_right,
  output logic        overflow,
  output logic [7:0]  err_count
`ifdef I2S_RX_FRAME_CNT_EN
  ,
  output logic [15:0] frame_count
`endif
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(2 * LOCK_FRAMES + 1);
  localparam int CW = $clog2(CAPTURE_DLY + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);
  localparam logic [GW-1:0] GOAL = GW'(2 * LOCK_FRAMES);

  typedef enum logic [1:0] {
    IDLE, SEARCH, LOCKING, LOCKED
  } state_t;

  state_t state, state_nxt;

  logic [1:0]    sck_sync, ws_sync;
  logic          sck_d, ws_prev;
  logic          sck_rise, ws_edge;
  logic          half_good, frame_done;
  logic [6:0]    bit_cnt;
  logic [TW-1:0] to_cnt, to_nxt;
  logic          timeout;
  logic [GW-1:0] good_cnt, good_nxt;
  logic [7:0]    err_nxt;
  logic          cap_pend;
  logic [CW-1:0] cap_cnt;
  logic          cap_fire, cap_load;

  assign sck_rise   = sck_sync[1] & ~sck_d;
  assign ws_edge    = sck_rise & (ws_sync[1] ^ ws_prev);
  assign half_good  = (bit_cnt == 7'(BITS_PER_CH));
  assign frame_done = ws_edge & half_good & ~ws_sync[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sck_sync <= '0;
      ws_sync  <= '0;
      sck_d    <= 1'b0;
      ws_prev  <= 1'b0;
      bit_cnt  <= '0;
      to_cnt   <= '0;
    end else begin
      sck_sync <= {sck_sync[0], sck};
      ws_sync  <= {ws_sync[0], ws};
      sck_d    <= sck_sync[1];
      to_cnt   <= to_nxt;
      if (sck_rise)
        ws_prev <= ws_sync[1];
      // first SCK of a new half-frame counts as bit 1
      if (ws_edge)
        bit_cnt <= 7'd1;
      else if (sck_rise && bit_cnt != 7'd127)
        bit_cnt <= bit_cnt + 7'd1;
    end
  end

  always_comb begin
    to_nxt = to_cnt;
    if (sck_rise)
      to_nxt = '0;
    else if (to_cnt != TMAX)
      to_nxt = to_cnt + TW'(1);
  end

  assign timeout = (to_nxt == TMAX);

  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    err_nxt   = err_count;
    unique case (state)
      IDLE:
        if (enable) state_nxt = SEARCH;
      SEARCH: begin
        good_nxt = '0;
        if (ws_edge) state_nxt = LOCKING;
      end
      LOCKING: begin
        if (ws_edge) begin
          good_nxt = half_good ? good_cnt + GW'(1) : '0;
          if (half_good && good_cnt == GOAL - GW'(1))
            state_nxt = LOCKED;
        end else if (timeout) begin
          state_nxt = SEARCH;
        end
      end
      LOCKED: begin
        if (ws_edge && !half_good) begin
          state_nxt = SEARCH;
          if (err_count != 8'hFF) err_nxt = err_count + 8'd1;
        end else if (timeout) begin
          state_nxt = SEARCH;
        end
      end
    endcase
    if (!enable) begin
      state_nxt = IDLE;
      good_nxt  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      good_cnt  <= '0;
      err_count <= '0;
    end else begin
      state     <= state_nxt;
      good_cnt  <= good_nxt;
      err_count <= err_nxt;
    end
  end

  assign locked = (state == LOCKED);
  assign rx_en  = locked;

  assign cap_fire = cap_pend & (cap_cnt == CW'(1)) & (state_nxt == LOCKED);
  assign cap_load = cap_fire & ~(smp_valid & ~smp_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_pend <= 1'b0;
      cap_cnt  <= '0;
    end else if (state_nxt != LOCKED) begin
      cap_pend <= 1'b0;
    end else if (state == LOCKED && frame_done) begin
      cap_pend <= 1'b1;
      cap_cnt  <= CW'(CAPTURE_DLY);
    end else if (cap_pend) begin
      cap_cnt <= cap_cnt - CW'(1);
      if (cap_cnt == CW'(1)) cap_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      smp_valid <= 1'b0;
      overflow  <= 1'b0;
      smp_left  <= '0;
      smp_right <= '0;
    end else if (!enable) begin
      smp_valid <= 1'b0;
      overflow  <= 1'b0;
    end else if (cap_fire) begin
      // a full, stalled output keeps the old sample
      if (!cap_load) begin
        overflow <= 1'b1;
      end else begin
        smp_valid <= 1'b1;
        smp_left  <= rx_data_left;
        smp_right <= rx_data_right;
      end
    end else if (smp_ready) begin
      smp_valid <= 1'b0;
    end
  end

`ifdef I2S_RX_FRAME_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      frame_count <= '0;
    else if (!enable || state == IDLE)
      frame_count <= '0;
    else if (cap_load)
      frame_count <= frame_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_i2s_rx_sequencer.sv
// Directed bench for i2s_rx_sequencer: lock, framing error, backpressure,
// simultaneous capture/transfer, timeout, enable drop and async reset.
module tb_i2s_rx_sequencer;

  localparam int TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        sck = 1'b0;
  logic        ws = 1'b0;
  logic        smp_ready = 1'b0;
  logic [31:0] rx_l = '0;
  logic [31:0] rx_r = '0;
  logic        rx_en, locked, smp_valid, overflow;
  logic [31:0] smp_left, smp_right;
  logic [7:0]  err_count;
`ifdef I2S_RX_FRAME_CNT_EN
  logic [15:0] frame_count;
`endif

  int n_run = 0;
  int n_fail = 0;
  int xfer_cnt = 0;
  int x0 = 0;
  int cyc = 0;
  logic [31:0] last_l = '0;
  logic [31:0] last_r = '0;
  event fc_ev;

  always #5 clk = ~clk;

  i2s_rx_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .sck           (sck),
    .ws            (ws),
    .rx_data_left  (rx_l),
    .rx_data_right (rx_r),
    .rx_en         (rx_en),
    .locked        (locked),
    .smp_valid     (smp_valid),
    .smp_ready     (smp_ready),
    .smp_left      (smp_left),
    .smp_right     (smp_right),
    .overflow      (overflow),
    .err_count     (err_count)
`ifdef I2S_RX_FRAME_CNT_EN
    ,
    .frame_count   (frame_count)
`endif
  );

  // inputs move only on negedges, so negedge+1 sees what the next posedge sees
  always begin
    @(negedge clk);
    #1;
    if (smp_valid && smp_ready) begin
      xfer_cnt <= xfer_cnt + 1;
      last_l   <= smp_left;
      last_r   <= smp_right;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // one half-frame of n bits, SCK = clk/4, WS changes while SCK low
  task automatic half(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sck = 1'b0;
      ws  = v;
      @(negedge clk);
      @(negedge clk);
      sck = 1'b1;
      if (i == 0 && !v) -> fc_ev;
      @(negedge clk);
    end
  endtask

  // half-frames a..b of a clean stream; even index = right (WS=1)
  task automatic run(input int a, input int b);
    for (int k = a; k <= b; k++)
      half((k % 2) == 0, 32);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_rx_en", 32'(rx_en), 0);
    chk("rst_valid", 32'(smp_valid), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_left", smp_left, 0);
    chk("rst_err", 32'(err_count), 0);

    rst = 1'b1;
    enable = 1'b1;
    smp_ready = 1'b1;
    rx_l = 32'hDEADBEEF;
    rx_r = 32'h0BADF00D;
    repeat (4) @(negedge clk);

    // lock: first edge leaves SEARCH, then 8 good edges
    run(0, 7);
    chk("s1_prelock", 32'(locked), 0);
    run(8, 8);
    chk("s1_locked", 32'(locked), 1);
    chk("s1_rx_en", 32'(rx_en), 1);
    fork
      run(9, 9);
      begin
        @(fc_ev);
        repeat (6) @(negedge clk);
        rx_l = 32'h12345678;
        rx_r = 32'h9ABCDEF0;
        @(negedge clk);
        rx_l = 32'hDEADBEEF;
        rx_r = 32'h0BADF00D;
      end
    join
    chk("s1_xfers", xfer_cnt, 1);
    chk("s1_left", last_l, 32'h12345678);
    chk("s1_right", last_r, 32'h9ABCDEF0);
    chk("s1_valid_low", 32'(smp_valid), 0);
`ifdef I2S_RX_FRAME_CNT_EN
    chk("s1_frame_cnt", 32'(frame_count), 1);
`endif

    // framing error: 31-bit half-frame
    half(1'b1, 31);
    chk("s2_still_locked", 32'(locked), 1);
    run(11, 11);
    chk("s2_unlocked", 32'(locked), 0);
    chk("s2_err", 32'(err_count), 1);
    run(12, 19);
    chk("s2_prerelock", 32'(locked), 0);
    run(20, 20);
    chk("s2_relocked", 32'(locked), 1);

    // simultaneous capture and transfer
    smp_ready = 1'b0;
    rx_l = 32'hA1A1A1A1;
    rx_r = 32'hB2B2B2B2;
    run(21, 22);
    chk("s4_hold_v", 32'(smp_valid), 1);
    chk("s4_hold_l", smp_left, 32'hA1A1A1A1);
    rx_l = 32'hC3C3C3C3;
    rx_r = 32'hD4D4D4D4;
    x0 = xfer_cnt;
    fork
      run(23, 23);
      begin
        @(fc_ev);
        repeat (6) @(negedge clk);
        chk("s4_old_l", smp_left, 32'hA1A1A1A1);
        smp_ready = 1'b1;
        @(negedge clk);
        chk("s4_valid", 32'(smp_valid), 1);
        chk("s4_new_l", smp_left, 32'hC3C3C3C3);
        chk("s4_new_r", smp_right, 32'hD4D4D4D4);
        chk("s4_ovf", 32'(overflow), 0);
        @(negedge clk);
        smp_ready = 1'b0;
        chk("s4_drained", 32'(smp_valid), 0);
      end
    join
    chk("s4_xfers", xfer_cnt - x0, 2);
    chk("s4_last_l", last_l, 32'hC3C3C3C3);

    // backpressure: hold first, drop second
    rx_l = 32'h55555555;
    rx_r = 32'h66666666;
    run(24, 25);
    chk("s3_v1", 32'(smp_valid), 1);
    chk("s3_l1", smp_left, 32'h55555555);
    chk("s3_ovf0", 32'(overflow), 0);
    rx_l = 32'h77777777;
    rx_r = 32'h88888888;
    run(26, 27);
    chk("s3_v2", 32'(smp_valid), 1);
    chk("s3_l2", smp_left, 32'h55555555);
    chk("s3_r2", smp_right, 32'h66666666);
    chk("s3_ovf1", 32'(overflow), 1);
    x0 = xfer_cnt;
    smp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("s3_valid_low", 32'(smp_valid), 0);
    chk("s3_one_xfer", xfer_cnt - x0, 1);
    chk("s3_xfer_r", last_r, 32'h66666666);

    // enable drop with a pending sample
    smp_ready = 1'b0;
    rx_l = 32'h9999AAAA;
    rx_r = 32'hBBBBCCCC;
    run(28, 29);
    chk("s6_pend_v", 32'(smp_valid), 1);
    enable = 1'b0;
    @(negedge clk);
    chk("s6_en_valid", 32'(smp_valid), 0);
    chk("s6_en_ovf", 32'(overflow), 0);
    chk("s6_en_locked", 32'(locked), 0);
    chk("s6_en_rx_en", 32'(rx_en), 0);
    chk("s6_en_err", 32'(err_count), 1);

    // timeout: relock, then stop SCK
    enable = 1'b1;
    repeat (3) @(negedge clk);
    run(30, 37);
    chk("s5_prelock", 32'(locked), 0);
    run(38, 38);
    chk("s5_locked", 32'(locked), 1);
    // last SCK high drive was one posedge ago; 3 posedges of sync latency
    cyc = 1;
    while (locked && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    chk("s5_timeout_cyc", cyc, TIMEOUT + 3);
    chk("s5_err", 32'(err_count), 1);

    // async reset mid-frame
    sck = 1'b0;
    fork
      run(39, 39);
      begin
        repeat (40) @(negedge clk);
        chk("s6_pre_left", smp_left, 32'h9999AAAA);
        #2 rst = 1'b0;
        #1;
        chk("s6_rst_locked", 32'(locked), 0);
        chk("s6_rst_rx_en", 32'(rx_en), 0);
        chk("s6_rst_valid", 32'(smp_valid), 0);
        chk("s6_rst_ovf", 32'(overflow), 0);
        chk("s6_rst_left", smp_left, 0);
        chk("s6_rst_right", smp_right, 0);
        chk("s6_rst_err", 32'(err_count), 0);
      end
    join
    rst = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
